// File: rtl/wi_weight_store_if.sv
// Request/response bundle for the weight store: read, burst, write and reinit requests in;
// registered read data with valid/done strobes and idle/init status out.
interface wi_weight_store_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] add;
  logic              rd_req;
  logic              burst_req;
  logic [ADDR_W-1:0] burst_len;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              reinit;
  logic [DATA_W-1:0] Wip;
  logic              rd_valid;
  logic              burst_done;
  logic              rdy;
  logic              busy;

  modport master (
    output add, rd_req, burst_req, burst_len, wr_en, wr_addr, wr_data, reinit,
    input  Wip, rd_valid, burst_done, rdy, busy
  );

  modport slave (
    input  add, rd_req, burst_req, burst_len, wr_en, wr_addr, wr_data, reinit,
    output Wip, rd_valid, burst_done, rdy, busy
  );
endinterface

// File: rtl/wi_weight_store.sv
// Writable weight RAM with a hardware default fill; single and wrapping burst reads, latency 1.
// No backpressure: requests are only taken while rdy=1 and are dropped otherwise; writes are dropped during fill.
module wi_weight_store #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 8,
  parameter logic [DATA_W-1:0] INIT_VAL       = 8'h02,
  parameter logic [DATA_W-1:0] INIT_ADDR0_VAL = 8'h00
) (
  input logic              CS,
  input logic              cen,
  wi_weight_store_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] wip_q;
  logic              rd_valid_q;
  logic              burst_done_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // The fill sequencer owns the write port while in INIT, so run-time writes are simply dropped there.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt;
      mem_wdata = (cnt == '0) ? INIT_ADDR0_VAL : INIT_VAL;
    end else if (bus.wr_en) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge CS) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // The first burst word is fetched on the accepting edge; ptr/remaining then track the words still owed.
  always_ff @(posedge CS or negedge cen) begin
    if (!cen) begin
      state        <= ST_INIT;
      cnt          <= '0;
      ptr          <= '0;
      remaining    <= '0;
      wip_q        <= '0;
      rd_valid_q   <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      rd_valid_q   <= 1'b0;
      burst_done_q <= 1'b0;
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (bus.reinit) begin
            cnt   <= '0;
            state <= ST_INIT;
          end else if (bus.burst_req) begin
            wip_q        <= mem[bus.add];
            rd_valid_q   <= 1'b1;
            ptr          <= bus.add + 1'b1;
            remaining    <= bus.burst_len;
            burst_done_q <= (bus.burst_len == '0);
            state        <= ST_BURST;
          end else if (bus.rd_req) begin
            wip_q      <= mem[bus.add];
            rd_valid_q <= 1'b1;
          end
        end
        ST_BURST: begin
          if (remaining == '0) begin
            state <= ST_IDLE;
          end else begin
            wip_q        <= mem[ptr];
            rd_valid_q   <= 1'b1;
            ptr          <= ptr + 1'b1;
            remaining    <= remaining - 1'b1;
            burst_done_q <= (remaining == ADDR_W'(1));
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.Wip        = wip_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.burst_done = burst_done_q;
  assign bus.rdy        = (state == ST_IDLE);
  assign bus.busy       = (state == ST_INIT);

endmodule

// File: tb/tb_wi_weight_store.sv
// Bench for wi_weight_store: vector table plus hand sequences, read words checked by a cycle-stamped scoreboard.
module tb_wi_weight_store;

  logic CS;
  logic cen;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  wi_weight_store_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  wi_weight_store #(
    .DATA_W(8), .ADDR_W(8), .INIT_VAL(8'h02), .INIT_ADDR0_VAL(8'h00)
  ) dut (
    .CS (CS),
    .cen(cen),
    .bus(bus)
  );

  initial begin
    CS = 1'b0;
    forever #5 CS = ~CS;
  end

  always @(posedge CS) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       done;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] ref_mem [256];

  // Read words are compared at the falling edge against the cycle they were promised for.
  always @(negedge CS) begin : monitor
    exp_t e;
    if (bus.rd_valid) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word cyc=%0d Wip=%h, required no word", cyc, bus.Wip);
      end else begin
        e = q.pop_front();
        if (bus.Wip !== e.data || bus.burst_done !== e.done || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL read_word cyc=%0d Wip=%h done=%b, required cyc=%0d Wip=%h done=%b",
                   cyc, bus.Wip, bus.burst_done, e.cyc, e.data, e.done);
        end
      end
    end else begin
      if (bus.burst_done !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL done_without_valid cyc=%0d burst_done=%b, required 0", cyc, bus.burst_done);
      end
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_word cyc=%0d rd_valid=0, required Wip=%h at cyc=%0d", cyc, e.data, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge CS);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.add       = '0;
    bus.rd_req    = 1'b0;
    bus.burst_req = 1'b0;
    bus.burst_len = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.reinit    = 1'b0;
  endtask

  task automatic ref_default();
    for (int i = 0; i < 256; i++) ref_mem[i] = (i == 0) ? 8'h00 : 8'h02;
  endtask

  task automatic push(input logic [7:0] d, input logic done, input int at);
    exp_t e;
    e.data = d;
    e.done = done;
    e.cyc  = at;
    q.push_back(e);
  endtask

  // 256 fill cycles follow the edge that enters INIT; optional requests are thrown at it meanwhile.
  task automatic fill_wait(input bit noise);
    for (int i = 0; i < 256; i++) begin
      idle_inputs();
      if (noise && (i == 5 || i == 100)) begin
        bus.rd_req = 1'b1;
        bus.add    = 8'd0;
      end
      if (noise && i == 50) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'd3;
        bus.wr_data = 8'hAA;
      end
      step();
      if (noise && (i == 5 || i == 100)) chk("init_rd_ignored", 32'(bus.rd_valid), 32'd0);
      if (i == 254) chk("busy_before_last_fill", 32'(bus.busy), 32'd1);
      if (i == 255) begin
        chk("busy_after_fill", 32'(bus.busy), 32'd0);
        chk("rdy_after_fill", 32'(bus.rdy), 32'd1);
      end
    end
    idle_inputs();
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    idle_inputs();
    bus.rd_req = 1'b1;
    bus.add    = a;
    push(exp, 1'b0, cyc + 1);
    step();
    idle_inputs();
  endtask

  typedef struct {
    logic       rd;
    logic [7:0] add;
    logic       wr;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{1'b1, 8'd7,   1'b1, 8'd7,   8'h5C, 8'h02};
    vt[1] = '{1'b1, 8'd7,   1'b0, 8'd0,   8'h00, 8'h5C};
    vt[2] = '{1'b1, 8'd0,   1'b0, 8'd0,   8'h00, 8'h00};
    vt[3] = '{1'b1, 8'd255, 1'b0, 8'd0,   8'h00, 8'h02};
    vt[4] = '{1'b1, 8'd3,   1'b0, 8'd0,   8'h00, 8'h02};
    vt[5] = '{1'b1, 8'd254, 1'b1, 8'd254, 8'h11, 8'h02};
    vt[6] = '{1'b1, 8'd254, 1'b1, 8'd255, 8'h22, 8'h11};
    vt[7] = '{1'b1, 8'd255, 1'b0, 8'd0,   8'h00, 8'h22};
    vt[8] = '{1'b0, 8'd0,   1'b1, 8'd100, 8'h3C, 8'h00};
    vt[9] = '{1'b1, 8'd100, 1'b0, 8'd0,   8'h00, 8'h3C};

    idle_inputs();
    cen = 1'b0;
    step();
    step();
    chk("reset_Wip", 32'(bus.Wip), 32'h0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_burst_done", 32'(bus.burst_done), 32'd0);
    chk("reset_rdy", 32'(bus.rdy), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd1);
    cen = 1'b1;
    fill_wait(1'b1);
    ref_default();

    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      bus.rd_req  = vt[i].rd;
      bus.add     = vt[i].add;
      bus.wr_en   = vt[i].wr;
      bus.wr_addr = vt[i].wa;
      bus.wr_data = vt[i].wd;
      if (vt[i].rd) push(vt[i].exp, 1'b0, cyc + 1);
      if (vt[i].wr) ref_mem[vt[i].wa] = vt[i].wd;
      step();
    end
    idle_inputs();
    step();

    // Wrapping burst across the top of memory.
    bus.burst_req = 1'b1;
    bus.add       = 8'd254;
    bus.burst_len = 8'd3;
    push(8'h11, 1'b0, cyc + 1);
    push(8'h22, 1'b0, cyc + 2);
    push(8'h00, 1'b0, cyc + 3);
    push(8'h02, 1'b1, cyc + 4);
    step();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      chk("burst_rdy_low", 32'(bus.rdy), 32'd0);
      step();
    end
    chk("burst_rdy_back", 32'(bus.rdy), 32'd1);

    // Single-word burst.
    bus.burst_req = 1'b1;
    bus.add       = 8'd7;
    bus.burst_len = 8'd0;
    push(8'h5C, 1'b1, cyc + 1);
    step();
    idle_inputs();
    chk("burst1_rdy_low", 32'(bus.rdy), 32'd0);
    step();
    chk("burst1_rdy_back", 32'(bus.rdy), 32'd1);

    // Whole-memory burst from a non-zero start.
    bus.burst_req = 1'b1;
    bus.add       = 8'd5;
    bus.burst_len = 8'd255;
    for (int k = 0; k < 256; k++) push(ref_mem[(5 + k) % 256], (k == 255), cyc + 1 + k);
    step();
    idle_inputs();
    repeat (256) step();
    chk("fullburst_rdy_back", 32'(bus.rdy), 32'd1);
    step();

    // Reset on the second word of a 10-word burst.
    bus.burst_req = 1'b1;
    bus.add       = 8'd0;
    bus.burst_len = 8'd9;
    push(ref_mem[0], 1'b0, cyc + 1);
    step();
    idle_inputs();
    step();
    cen = 1'b0;
    #1;
    chk("midburst_reset_Wip", 32'(bus.Wip), 32'h0);
    chk("midburst_reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("midburst_reset_busy", 32'(bus.busy), 32'd1);
    step();
    cen = 1'b1;
    fill_wait(1'b0);
    ref_default();
    rd(8'd7, 8'h02);

    // reinit beats a simultaneous read.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'd9;
    bus.wr_data = 8'hFF;
    step();
    idle_inputs();
    rd(8'd9, 8'hFF);
    bus.reinit = 1'b1;
    bus.rd_req = 1'b1;
    bus.add    = 8'd9;
    step();
    idle_inputs();
    chk("reinit_busy", 32'(bus.busy), 32'd1);
    chk("reinit_no_valid", 32'(bus.rd_valid), 32'd0);
    fill_wait(1'b0);
    rd(8'd9, 8'h02);

    repeat (3) step();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
